// File: rtl/lcd_bcd_writer.sv
// Writes one 3-digit BCD field to an HD44780-style LCD: a set-DDRAM-address command, then three ASCII digits.
// Latency: start is accepted in IDLE; busy for exactly 4*(SETUP_CYC+E_HIGH_CYC+WAIT_CYC) cycles, then a single done pulse.
// Backpressure: start is ignored while busy; a start held high through the done cycle begins the next field at once.
//
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   start, addr               - field request and DDRAM address of the hundreds digit
//   hundreds, tens, ones      - BCD digits, captured when start is accepted
//   lcd_rs, lcd_rw, lcd_e,
//   lcd_data                  - LCD bus; lcd_rw is tied low because the LCD is never read
//   busy, done                - write in progress / one-cycle completion pulse
//
// Build option: define LCD_BLANK_LEAD_ZERO_EN to print leading zeros of the
// hundreds and tens positions as spaces. The ones digit is always shown.

module lcd_bcd_writer #(
    parameter int unsigned SETUP_CYC  = 4,     // RS/DATA stable before E rises, 1..255
    parameter int unsigned E_HIGH_CYC = 24,    // E high time, 1..255
    parameter int unsigned WAIT_CYC   = 2000   // settle time after E falls, 1..65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EHI   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;        // remaining cycles in the current state, minus one
    logic [15:0] cnt_load;   // value loaded when entering state_nxt
    logic [1:0]  idx;        // byte index: 0 = address command, 1..3 = digits
    logic [1:0]  idx_inc;
    logic [6:0]  addr_q;
    logic [1:0]  hund_q;
    logic [3:0]  tens_q;
    logic [3:0]  ones_q;
    logic        blank_h;
    logic        blank_t;
    logic [7:0]  byte_nxt;
    logic        last_cyc;   // final cycle of the current state

    // Digits 0..9 become '0'..'9'; out-of-range BCD shows '?'.
    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
        logic [7:0] c;
        if (blank) begin
            c = 8'h20;
        end else if (d > 4'd9) begin
            c = 8'h3F;
        end else begin
            c = 8'h30 + {4'h0, d};
        end
        return c;
    endfunction

`ifdef LCD_BLANK_LEAD_ZERO_EN
    assign blank_h = (hund_q == 2'd0);
    assign blank_t = (hund_q == 2'd0) && (tens_q == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    assign last_cyc = (cnt == 16'd0);
    assign idx_inc  = idx + 2'd1;

    // Byte presented when moving from WAIT of byte idx to SETUP of byte idx+1.
    always_comb begin
        byte_nxt = 8'h00;
        case (idx_inc)
            2'd1:    byte_nxt = digit_char({2'b00, hund_q}, blank_h);
            2'd2:    byte_nxt = digit_char(tens_q, blank_t);
            2'd3:    byte_nxt = digit_char(ones_q, 1'b0);
            default: byte_nxt = {1'b1, addr_q};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start)    state_nxt = SETUP;
            SETUP: if (last_cyc) state_nxt = EHI;
            EHI:   if (last_cyc) state_nxt = WAIT;
            WAIT:  if (last_cyc) state_nxt = (idx == 2'd3) ? IDLE : SETUP;
            default:             state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        lcd_e  = (state == EHI);
        busy   = (state != IDLE);
        lcd_rw = 1'b0;
    end

    always_comb begin
        cnt_load = 16'd0;
        case (state_nxt)
            SETUP:   cnt_load = 16'(SETUP_CYC - 1);
            EHI:     cnt_load = 16'(E_HIGH_CYC - 1);
            WAIT:    cnt_load = 16'(WAIT_CYC - 1);
            default: cnt_load = 16'd0;
        endcase
    end

    // Timing counter, byte index, captured field and bus data.
    // RS/DATA change only on entry to SETUP, so they stay fixed through EHI and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 16'd0;
            idx      <= 2'd0;
            addr_q   <= 7'd0;
            hund_q   <= 2'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= (state == WAIT) && last_cyc && (idx == 2'd3);

            if (state_nxt != state) begin
                cnt <= cnt_load;
            end else if (!last_cyc) begin
                cnt <= cnt - 16'd1;
            end

            if (state == IDLE && start) begin
                addr_q   <= addr;
                hund_q   <= hundreds;
                tens_q   <= tens;
                ones_q   <= ones;
                idx      <= 2'd0;
                lcd_rs   <= 1'b0;
                lcd_data <= {1'b1, addr};
            end else if (state == WAIT && state_nxt == SETUP) begin
                idx      <= idx_inc;
                lcd_rs   <= 1'b1;
                lcd_data <= byte_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bcd_writer.sv
// Bench for lcd_bcd_writer with short timing (2/3/4 cycles per phase).
// A field-level model predicts every output cycle; directed tests also check literal byte values.
module tb_lcd_bcd_writer;

    localparam int S = 2;
    localparam int E = 3;
    localparam int W = 4;
    localparam int BYTE_CYC  = S + E + W;
    localparam int FIELD_CYC = 4 * BYTE_CYC;

`ifdef LCD_BLANK_LEAD_ZERO_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    lcd_bcd_writer #(
        .SETUP_CYC (S),
        .E_HIGH_CYC(E),
        .WAIT_CYC  (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- field-level model ----------------
    // m_pos = cycle position within the busy window, -1 when idle.
    int         m_pos = -1;
    logic [8:0] m_bytes [4];   // {rs, data}
    bit         m_done = 1'b0;
    bit         cmp_en = 1'b0;

    function automatic logic [7:0] ascii(input int d, input bit blank);
        if (blank) return 8'h20;
        if (d > 9) return 8'h3F;
        return 8'(48 + d);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FIELD_CYC) begin
                    m_pos  = -1;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_bytes[0] = {1'b0, 8'h80 + 8'(addr)};
                m_bytes[1] = {1'b1, ascii(int'(hundreds), BLANK && hundreds == 0)};
                m_bytes[2] = {1'b1, ascii(int'(tens), BLANK && hundreds == 0 && tens == 0)};
                m_bytes[3] = {1'b1, ascii(int'(ones), 1'b0)};
                m_pos = 0;
            end
        end
    end

    // Compare process: every cycle after the initial reset.
    int ph;
    int bi;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rw_low", lcd_rw, 0);
            chk("busy", busy, (m_pos >= 0) ? 1 : 0);
            chk("done", done, m_done ? 1 : 0);
            if (m_pos >= 0) begin
                ph = m_pos % BYTE_CYC;
                bi = m_pos / BYTE_CYC;
                chk("lcd_e", lcd_e, (ph >= S && ph < S + E) ? 1 : 0);
                chk("lcd_rs", lcd_rs, int'(m_bytes[bi][8]));
                chk("lcd_data", lcd_data, int'(m_bytes[bi][7:0]));
            end else begin
                chk("lcd_e_idle", lcd_e, 0);
            end
        end
    end

    // ---------------- bus monitor for literal checks ----------------
    logic [8:0] cap_q [$];
    int         elen_q [$];
    int         e_len = 0;
    logic       prev_e = 1'b0;
    int         mon_busy = 0;
    int         mon_done = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (busy) mon_busy++;
            if (done) mon_done++;
            if (lcd_e && !prev_e) cap_q.push_back({lcd_rs, lcd_data});
            if (lcd_e) begin
                e_len++;
            end else if (prev_e) begin
                elen_q.push_back(e_len);
                e_len = 0;
            end
            prev_e = lcd_e;
        end
    end

    task automatic clear_mon();
        cap_q.delete();
        elen_q.delete();
        e_len    = 0;
        mon_busy = 0;
        mon_done = 0;
    endtask

    // Steps to just after the negedge at which done is seen.
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) chk({name, "_done_wait"}, done, 1);
    endtask

    task automatic check_field(input string name, input logic [8:0] exp [4]);
        chk({name, "_nbytes"}, cap_q.size(), 4);
        for (int i = 0; i < 4 && i < cap_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), int'(cap_q[i]), int'(exp[i]));
        for (int i = 0; i < elen_q.size(); i++)
            chk($sformatf("%s_ewidth%0d", name, i), elen_q[i], E);
        chk({name, "_busy_cycles"}, mon_busy, FIELD_CYC);
        chk({name, "_done_pulses"}, mon_done, 1);
    endtask

    task automatic kick(input logic [6:0] a, input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
        @(negedge clk);
        #1;
        addr = a; hundreds = h; tens = t; ones = o;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; addr = '0; hundreds = '0; tens = '0; ones = '0;
        repeat (3) @(negedge clk);
        #1;
        // Reset state, with start asserted to confirm rst wins.
        start = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_lcd_data", lcd_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        rst   = 1'b0;
        cmp_en = 1'b1;

        // addr 0x40, 2/5/5
        clear_mon();
        kick(7'h40, 2'd2, 4'd5, 4'd5);
        wait_done("f255");
        check_field("f255", '{9'h0C0, 9'h132, 9'h135, 9'h135});
        repeat (3) @(negedge clk);
        #1;
        chk("f255_single_done", mon_done, 1);

        // 0/0/7: leading-zero handling
        clear_mon();
        kick(7'h05, 2'd0, 4'd0, 4'd7);
        wait_done("f007");
        if (BLANK) check_field("f007", '{9'h085, 9'h120, 9'h120, 9'h137});
        else       check_field("f007", '{9'h085, 9'h130, 9'h130, 9'h137});

        // Out-of-range tens digit
        clear_mon();
        kick(7'h00, 2'd1, 4'hC, 4'd3);
        wait_done("f1c3");
        check_field("f1c3", '{9'h080, 9'h131, 9'h13F, 9'h133});

        // start held high; inputs change mid-write
        clear_mon();
        @(negedge clk);
        #1;
        addr = 7'h10; hundreds = 2'd1; tens = 4'd2; ones = 4'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        addr = 7'h20; hundreds = 2'd3; tens = 4'd4; ones = 4'd5;
        wait_done("held1");
        check_field("held1", '{9'h090, 9'h131, 9'h132, 9'h133});
        clear_mon();
        @(negedge clk);
        #1;
        chk("held_restart_busy", busy, 1);
        start = 1'b0;
        addr = 7'h7F; hundreds = 2'd0; tens = 4'd9; ones = 4'd9;
        wait_done("held2");
        check_field("held2", '{9'h0A0, 9'h133, 9'h134, 9'h135});

        // Reset during EHI of byte 2
        clear_mon();
        kick(7'h01, 2'd2, 4'd5, 4'd5);
        for (int i = 0; i < 100 && cap_q.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_reached_byte2", cap_q.size(), 3);
        chk("abort_e_high", lcd_e, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_lcd_e", lcd_e, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", lcd_data, 8'h00);
        chk("abort_rs", lcd_rs, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_done", mon_done, 0);
        clear_mon();
        kick(7'h01, 2'd2, 4'd5, 4'd5);
        wait_done("after_abort");
        check_field("after_abort", '{9'h081, 9'h132, 9'h135, 9'h135});

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
